// File: rtl/mux_3to1_if.sv
// Bus interface for the 3-to-1 word multiplexer: data inputs, select code,
// combinational and registered selected word.
interface mux_3to1_if #(
   parameter int WIDTH = 32
);

   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [1:0]       s;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_q;

   // The datapath side that supplies operands and consumes the selection
   modport master (
      output d0,
      output d1,
      output d2,
      output s,
      input  y,
      input  y_q
   );

   // The multiplexer itself
   modport slave (
      input  d0,
      input  d1,
      input  d2,
      input  s,
      output y,
      output y_q
   );

endinterface

// File: rtl/mux_3to1.sv
// Three-input WIDTH-bit word multiplexer for operand forwarding and
// writeback selection. y is purely combinational; y_q is the same word
// registered one clock later. Select code 2'b11 aliases to d2, so s[1]
// alone decides between d2 and the lower pair.
module mux_3to1 #(
   parameter int WIDTH = 32
) (
   input logic        clk,
   input logic        reset,
   mux_3to1_if.slave  bus
);

   logic [WIDTH-1:0] ySel;

   // Select the word: s[1] wins over s[0], so both 2'b10 and 2'b11 pick d2
   always_comb begin
      ySel = bus.d0;
      if (bus.s[1]) begin
         ySel = bus.d2;
      end else if (bus.s[0]) begin
         ySel = bus.d1;
      end
   end

   assign bus.y = ySel;

   // Register the selected word for the next pipeline stage; reset clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.y_q <= '0;
      end else begin
         bus.y_q <= ySel;
      end
   end

endmodule

// File: tb/tb_mux_3to1.sv
// Self-checking bench for mux_3to1: combinational selection patterns,
// random data, registered path with reset, back-to-back pipelined words,
// and a WIDTH = 1 instance.
module tb_mux_3to1;

   logic clk;
   logic reset;

   int testsRun;
   int testsFailed;

   logic [31:0] expQ[$];
   logic [31:0] expVal;

   mux_3to1_if #(.WIDTH(32)) bus ();
   mux_3to1_if #(.WIDTH(1))  bus1 ();

   mux_3to1 #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   mux_3to1 #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference selection written as a full case over the select code
   function automatic logic [31:0] modelMux(input logic [31:0] a0,
                                            input logic [31:0] a1,
                                            input logic [31:0] a2,
                                            input logic [1:0]  sel);
      case (sel)
         2'd0:    return a0;
         2'd1:    return a1;
         default: return a2;
      endcase
   endfunction

   task automatic test_reset();
      @(negedge clk);
      reset  = 1'b1;
      bus.d0 = 32'hDEADBEEF;
      bus.s  = 2'b00;
      expQ.push_back(32'h0000_0000);
      @(posedge clk);
      #1;
      expVal = expQ.pop_front();
      testsRun++;
      if (bus.y_q !== expVal) begin
         testsFailed++;
         $display("[TB] FAIL reset_yq: got %h expected %h", bus.y_q, expVal);
      end
   endtask

   task automatic test_patterns();
      logic [31:0] exp4[4];
      bus.d0 = 32'hAAAAAAAA;
      bus.d1 = 32'h55555555;
      bus.d2 = 32'hFFFFFFFF;
      exp4[0] = 32'hAAAAAAAA;
      exp4[1] = 32'h55555555;
      exp4[2] = 32'hFFFFFFFF;
      exp4[3] = 32'hFFFFFFFF;
      for (int i = 0; i < 4; i++) begin
         bus.s = 2'(i);
         expQ.push_back(exp4[i]);
         #1;
         expVal = expQ.pop_front();
         testsRun++;
         if (bus.y !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL pattern_s%0d: got %h expected %h", i, bus.y, expVal);
         end
      end
   endtask

   task automatic test_sweep();
      logic [31:0] exp4[4];
      bus.d0 = 32'h00000000;
      bus.d1 = 32'hFFFF0000;
      bus.d2 = 32'h0000FFFF;
      exp4[0] = 32'h00000000;
      exp4[1] = 32'hFFFF0000;
      exp4[2] = 32'h0000FFFF;
      exp4[3] = 32'h0000FFFF;
      for (int i = 0; i < 4; i++) begin
         bus.s = 2'(i);
         expQ.push_back(exp4[i]);
         #1;
         expVal = expQ.pop_front();
         testsRun++;
         if (bus.y !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL sweep_s%0d: got %h expected %h", i, bus.y, expVal);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 4; i++) begin
            bus.d0 = $urandom;
            bus.d1 = $urandom;
            bus.d2 = $urandom;
            bus.s  = 2'(i);
            expQ.push_back(modelMux(bus.d0, bus.d1, bus.d2, bus.s));
            #1;
            expVal = expQ.pop_front();
            testsRun++;
            if (bus.y !== expVal) begin
               testsFailed++;
               $display("[TB] FAIL random_n%0d_s%0d: got %h expected %h", n, i, bus.y, expVal);
            end
         end
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      reset = 1'b1;
      expQ.push_back(32'h0000_0000);
      @(posedge clk);
      #1;
      expVal = expQ.pop_front();
      testsRun++;
      if (bus.y_q !== expVal) begin
         testsFailed++;
         $display("[TB] FAIL reg_reset_yq: got %h expected %h", bus.y_q, expVal);
      end
      @(negedge clk);
      reset  = 1'b0;
      bus.s  = 2'b01;
      bus.d1 = 32'h12345678;
      #1;
      testsRun++;
      if (bus.y !== 32'h12345678) begin
         testsFailed++;
         $display("[TB] FAIL reg_y_before: got %h expected %h", bus.y, 32'h12345678);
      end
      expQ.push_back(32'h12345678);
      @(posedge clk);
      #1;
      expVal = expQ.pop_front();
      testsRun++;
      if (bus.y_q !== expVal) begin
         testsFailed++;
         $display("[TB] FAIL reg_yq_latency: got %h expected %h", bus.y_q, expVal);
      end
      testsRun++;
      if (bus.y !== 32'h12345678) begin
         testsFailed++;
         $display("[TB] FAIL reg_y_after: got %h expected %h", bus.y, 32'h12345678);
      end
   endtask

   task automatic test_midrun_reset();
      @(negedge clk);
      bus.d2 = 32'hFFFFFFFF;
      bus.s  = 2'b10;
      expQ.push_back(32'hFFFFFFFF);
      @(posedge clk);
      #1;
      expVal = expQ.pop_front();
      testsRun++;
      if (bus.y_q !== expVal) begin
         testsFailed++;
         $display("[TB] FAIL midrun_pre_yq: got %h expected %h", bus.y_q, expVal);
      end
      @(negedge clk);
      reset = 1'b1;
      expQ.push_back(32'h00000000);
      @(posedge clk);
      #1;
      expVal = expQ.pop_front();
      testsRun++;
      if (bus.y_q !== expVal) begin
         testsFailed++;
         $display("[TB] FAIL midrun_reset_yq: got %h expected %h", bus.y_q, expVal);
      end
      testsRun++;
      if (bus.y !== 32'hFFFFFFFF) begin
         testsFailed++;
         $display("[TB] FAIL midrun_reset_y: got %h expected %h", bus.y, 32'hFFFFFFFF);
      end
      @(negedge clk);
      reset = 1'b0;
      expQ.push_back(32'hFFFFFFFF);
      @(posedge clk);
      #1;
      expVal = expQ.pop_front();
      testsRun++;
      if (bus.y_q !== expVal) begin
         testsFailed++;
         $display("[TB] FAIL midrun_release_yq: got %h expected %h", bus.y_q, expVal);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         bus.d0 = $urandom;
         bus.d1 = $urandom;
         bus.d2 = $urandom;
         bus.s  = 2'($urandom_range(0, 3));
         expQ.push_back(modelMux(bus.d0, bus.d1, bus.d2, bus.s));
         @(posedge clk);
         #1;
         expVal = expQ.pop_front();
         testsRun++;
         if (bus.y_q !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL b2b_yq_%0d: got %h expected %h", n, bus.y_q, expVal);
         end
      end
   endtask

   task automatic test_width1();
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.d0 = v[0];
            bus1.d1 = v[1];
            bus1.d2 = v[2];
            bus1.s  = 2'(i);
            w0 = {31'b0, v[0]};
            w1 = {31'b0, v[1]};
            w2 = {31'b0, v[2]};
            expQ.push_back(modelMux(w0, w1, w2, 2'(i)));
            #1;
            expVal = expQ.pop_front();
            testsRun++;
            if ({31'b0, bus1.y} !== expVal) begin
               testsFailed++;
               $display("[TB] FAIL w1_y_v%0d_s%0d: got %b expected %b", v, i, bus1.y, expVal[0]);
            end
            expQ.push_back(expVal);
            @(posedge clk);
            #1;
            expVal = expQ.pop_front();
            testsRun++;
            if ({31'b0, bus1.y_q} !== expVal) begin
               testsFailed++;
               $display("[TB] FAIL w1_yq_v%0d_s%0d: got %b expected %b", v, i, bus1.y_q, expVal[0]);
            end
         end
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset   = 1'b0;
      bus.d0  = '0;
      bus.d1  = '0;
      bus.d2  = '0;
      bus.s   = '0;
      bus1.d0 = '0;
      bus1.d1 = '0;
      bus1.d2 = '0;
      bus1.s  = '0;

      test_reset();
      test_patterns();
      test_sweep();
      test_random();
      test_registered();
      test_midrun_reset();
      test_back_to_back();
      reset = 1'b0;
      test_width1();

      testsRun++;
      if (expQ.size() !== 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
